memory_system: RTL

//  Memory side of the processor's two bus interfaces: answers instruction fetches
//  (i_addr/i_rd -> i_data) and data accesses (d_addr/d_rd/d_wr/w_data -> r_data).

---
 rtl/memory_system.sv | 111 +++++++++++
 1 files changed

// File: rtl/memory_system.sv
// Instruction RAM, 256x16 data RAM and boot loader for the processor's two bus ports.
// cpu_rst holds the processor in reset until a program has streamed in on the load port.
module memory_system #(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter bit          BOOT_LOAD  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_addr,
    input  logic        i_rd,
    output logic [15:0] i_data,
    input  logic [7:0]  d_addr,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [15:0] w_data,
    output logic [15:0] r_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [15:0] ld_data,
    input  logic        ld_last,
    output logic        cpu_rst,
    output logic [15:0] loaded
);
    localparam int unsigned AW = $clog2(IMEM_DEPTH);

    localparam logic [0:0] S_LOAD = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] ld_ptr_q, ld_ptr_d;
    logic [15:0]   loaded_q, loaded_d;
    logic [15:0]   i_data_q, i_data_d;
    logic [15:0]   r_data_q, r_data_d;
    logic          ld_ready_q;
    logic          cpu_rst_q;

    logic [15:0]   imem [0:IMEM_DEPTH-1];
    logic [15:0]   dmem [0:255];

    logic          run;
    logic          beat;
    logic          last_beat;
    logic          i_oob;

    assign run       = (state_q == S_RUN);
    assign beat      = (state_q == S_LOAD) && ld_valid && ld_ready_q;
    // Filling the final slot ends the load even without ld_last, so ld_ptr never wraps.
    assign last_beat = beat && (ld_last || (ld_ptr_q == AW'(IMEM_DEPTH - 1)));
    assign i_oob     = ({16'd0, i_addr} >= IMEM_DEPTH);

    always_comb begin
        state_d  = state_q;
        ld_ptr_d = ld_ptr_q;
        loaded_d = loaded_q;
        i_data_d = i_data_q;
        r_data_d = r_data_q;

        if (beat) begin
            ld_ptr_d = ld_ptr_q + AW'(1);
            loaded_d = loaded_q + 16'd1;
        end
        if (last_beat) begin
            state_d = S_RUN;
        end

        if (run && i_rd) begin
            i_data_d = i_oob ? '0 : imem[i_addr[AW-1:0]];
        end
        // Read sees the pre-edge word, so a simultaneous write returns the old data.
        if (run && d_rd) begin
            r_data_d = dmem[d_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT_LOAD ? S_LOAD : S_RUN;
            ld_ptr_q   <= '0;
            loaded_q   <= '0;
            i_data_q   <= '0;
            r_data_q   <= '0;
            ld_ready_q <= 1'b0;
            cpu_rst_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            ld_ptr_q   <= ld_ptr_d;
            loaded_q   <= loaded_d;
            i_data_q   <= i_data_d;
            r_data_q   <= r_data_d;
            // ready drops on the accepting edge; cpu_rst follows one edge later.
            ld_ready_q <= (state_d == S_LOAD);
            cpu_rst_q  <= (state_q != S_RUN);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && beat) begin
            imem[ld_ptr_q] <= ld_data;
        end
        if (!rst && run && d_wr) begin
            dmem[d_addr] <= w_data;
        end
    end

    assign i_data   = i_data_q;
    assign r_data   = r_data_q;
    assign ld_ready = ld_ready_q;
    assign cpu_rst  = cpu_rst_q;
    assign loaded   = loaded_q;

endmodule
